dl_fpu_seq: RTL



---
 rtl/dl_fpu_seq_if.sv | 67 ++++++
 rtl/dl_fpu_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_fpu_seq_if.sv
// ---------------------------------------------------------------------------
// dl_fpu_seq_if
// Bundles every non-clock/reset signal of the DLFloat16 FPU sequencer:
//   - instruction stream in   : in_valid/in_ready, in_instr, in_op1..3, frm
//   - execution-unit side     : unit_req/op/sel/rm/a/b/c out, unit_done,
//                               unit_result, unit_excep in
//   - result stream out       : out_valid/out_ready, out_result, out_excep
//   - status / control        : fflags, fflags_clr, busy, timeout
// Modports:
//   slave  - the sequencer itself
//   master - its environment (instruction source, units, result sink)
// ---------------------------------------------------------------------------
interface dl_fpu_seq_if #(
  parameter int XLEN      = 32,
  parameter int NUM_UNITS = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_op1;
  logic [XLEN-1:0]      in_op2;
  logic [XLEN-1:0]      in_op3;
  logic [2:0]           frm;

  logic [NUM_UNITS-1:0] unit_req;
  logic                 unit_op;
  logic [2:0]           unit_sel;
  logic [2:0]           unit_rm;
  logic [XLEN-1:0]      unit_a;
  logic [XLEN-1:0]      unit_b;
  logic [XLEN-1:0]      unit_c;
  logic [NUM_UNITS-1:0] unit_done;
  logic [XLEN-1:0]      unit_result;
  logic [4:0]           unit_excep;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_result;
  logic [4:0]           out_excep;

  logic [4:0]           fflags;
  logic                 fflags_clr;
  logic                 busy;
  logic                 timeout;

  modport slave (
    input  in_valid, in_instr, in_op1, in_op2, in_op3, frm,
    output in_ready,
    output unit_req, unit_op, unit_sel, unit_rm, unit_a, unit_b, unit_c,
    input  unit_done, unit_result, unit_excep,
    output out_valid, out_result, out_excep,
    input  out_ready,
    output fflags, busy, timeout,
    input  fflags_clr
  );

  modport master (
    output in_valid, in_instr, in_op1, in_op2, in_op3, frm,
    input  in_ready,
    input  unit_req, unit_op, unit_sel, unit_rm, unit_a, unit_b, unit_c,
    output unit_done, unit_result, unit_excep,
    input  out_valid, out_result, out_excep,
    output out_ready,
    input  fflags, busy, timeout,
    output fflags_clr
  );
endinterface

// File: rtl/dl_fpu_seq.sv
// ---------------------------------------------------------------------------
// dl_fpu_seq
// In-order issue sequencer for the DLFloat16 FPU. Instructions plus operands
// are queued in a DEPTH-entry FIFO, then dispatched one at a time to one of
// NUM_UNITS external execution units. The unit's result and exception flags
// are returned over a valid/ready stream, and a sticky 5-bit fflags register
// accumulates {NV,DZ,OF,UF,NX}.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (drops in-flight and queued work)
//   bus  - dl_fpu_seq_if.slave: instruction stream, unit interface, result
//          stream, fflags/fflags_clr, busy, timeout
//
// Instruction fields: [31:27] unit index, [26] op, [25:23] sel, [14:12] rm
// (rm=111 selects the dynamic rounding mode frm).
//
// Optional build macro DLFPU_TIMEOUT_EN: when defined, a WAIT that lasts
// TIMEOUT cycles without the unit's done is forced to complete with result 0
// and NV, and a one-cycle timeout pulse is raised. When undefined, WAIT
// waits indefinitely and timeout is tied low.
// ---------------------------------------------------------------------------
module dl_fpu_seq #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 9,
  parameter int TIMEOUT   = 64
) (
  input logic         clk,
  input logic         rst,
  dl_fpu_seq_if.slave bus
);

  localparam int             AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL_C = CW'(DEPTH);
  localparam logic [4:0]     NV_C   = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // -------------------------------------------------------------------------
  // Instruction FIFO. Only the instruction fields the sequencer uses are
  // stored: {idx[4:0], op, sel[2:0], rm[2:0]}.
  // -------------------------------------------------------------------------
  logic [11:0]     mem_ctl_q [DEPTH];
  logic [XLEN-1:0] mem_a_q   [DEPTH];
  logic [XLEN-1:0] mem_b_q   [DEPTH];
  logic [XLEN-1:0] mem_c_q   [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            in_ready;
  logic            push;
  logic            pop;

  state_t          state_q, state_d;

  // Issue registers: loaded by the FIFO's registered read on pop and held
  // untouched until the next pop, so the unit sees stable operands from
  // ISSUE through the end of WAIT.
  logic [11:0]     iss_ctl_q;
  logic [XLEN-1:0] iss_a_q;
  logic [XLEN-1:0] iss_b_q;
  logic [XLEN-1:0] iss_c_q;

  logic [4:0]      iss_idx;
  logic            iss_op;
  logic [2:0]      iss_sel;
  logic [2:0]      iss_rm_field;

  logic [2:0]      rm_res;
  logic            idx_bad;
  logic            rm_bad;
  logic            illegal;

  logic [2:0]      rm_q, rm_d;
  logic [XLEN-1:0] out_result_q;
  logic [4:0]      out_excep_q;
  logic [4:0]      fflags_q, fflags_d;

  logic            cap_en;
  logic [XLEN-1:0] cap_result;
  logic [4:0]      cap_excep;

  logic [NUM_UNITS-1:0] sel_mask;
  logic                 done_hit;

  // Instruction bits the sequencer does not interpret.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.in_instr[22:15], bus.in_instr[11:0]};

  // in_ready depends only on the registered count: a full FIFO refuses a
  // push even when the FSM pops in the same cycle.
  assign in_ready = (count_q != FULL_C);
  assign push     = bus.in_valid & in_ready;
  assign pop      = (state_q == S_IDLE) & (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ctl_q[wr_ptr_q] <= {bus.in_instr[31:23], bus.in_instr[14:12]};
      mem_a_q[wr_ptr_q]   <= bus.in_op1;
      mem_b_q[wr_ptr_q]   <= bus.in_op2;
      mem_c_q[wr_ptr_q]   <= bus.in_op3;
    end
    if (pop) begin
      iss_ctl_q <= mem_ctl_q[rd_ptr_q];
      iss_a_q   <= mem_a_q[rd_ptr_q];
      iss_b_q   <= mem_b_q[rd_ptr_q];
      iss_c_q   <= mem_c_q[rd_ptr_q];
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  assign iss_idx      = iss_ctl_q[11:7];
  assign iss_op       = iss_ctl_q[6];
  assign iss_sel      = iss_ctl_q[5:3];
  assign iss_rm_field = iss_ctl_q[2:0];

  assign rm_res  = (iss_rm_field == 3'b111) ? bus.frm : iss_rm_field;
  assign idx_bad = (32'(iss_idx) >= NUM_UNITS);
  assign rm_bad  = (rm_res inside {3'b101, 3'b110, 3'b111}) ||
                   (iss_rm_field inside {3'b101, 3'b110});
  assign illegal = idx_bad | rm_bad;

  // One-hot decode of the issued unit index. It is used both for the start
  // pulse and to mask unit_done so that only the issued unit is honoured.
  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_sel
      assign sel_mask[gi] = (iss_idx == 5'(gi));
    end
  endgenerate

  assign done_hit = |(bus.unit_done & sel_mask);

  // -------------------------------------------------------------------------
  // Optional WAIT watchdog
  // -------------------------------------------------------------------------
`ifdef DLFPU_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;
  logic           expire;

  // Counter reads 0 in the first WAIT cycle; expiry is in the TIMEOUT-th
  // WAIT cycle.
  assign wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + TCW'(1) : '0;
  assign expire     = (state_q == S_WAIT) && (wait_cnt_q == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  localparam int unused_timeout_c = TIMEOUT;
  assign bus.timeout = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM next-state and capture logic. cap_en is asserted exactly on the
  // transitions into RESP, which is also when fflags absorbs the new flags.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rm_d       = rm_q;
    cap_en     = 1'b0;
    cap_result = '0;
    cap_excep  = '0;
`ifdef DLFPU_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rm_d = rm_res;
        if (illegal) begin
          cap_en    = 1'b1;
          cap_excep = NV_C;
          state_d   = S_RESP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the expiry cycle wins over the watchdog.
        if (done_hit) begin
          cap_en     = 1'b1;
          cap_result = bus.unit_result;
          cap_excep  = bus.unit_excep;
          state_d    = S_RESP;
        end
`ifdef DLFPU_TIMEOUT_EN
        else if (expire) begin
          cap_en    = 1'b1;
          cap_excep = NV_C;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A new flag set on RESP entry survives a simultaneous clear.
  always_comb begin
    fflags_d = bus.fflags_clr ? 5'b00000 : fflags_q;
    if (cap_en) begin
      fflags_d = fflags_d | cap_excep;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rm_q         <= '0;
      out_result_q <= '0;
      out_excep_q  <= '0;
      fflags_q     <= '0;
    end else begin
      state_q  <= state_d;
      rm_q     <= rm_d;
      fflags_q <= fflags_d;
      if (cap_en) begin
        out_result_q <= cap_result;
        out_excep_q  <= cap_excep;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready   = in_ready;
  assign bus.unit_req   = (state_q == S_ISSUE) ? sel_mask : '0;
  assign bus.unit_op    = iss_op;
  assign bus.unit_sel   = iss_sel;
  assign bus.unit_rm    = rm_q;
  assign bus.unit_a     = iss_a_q;
  assign bus.unit_b     = iss_b_q;
  assign bus.unit_c     = iss_c_q;
  assign bus.out_valid  = (state_q == S_RESP);
  assign bus.out_result = out_result_q;
  assign bus.out_excep  = out_excep_q;
  assign bus.fflags     = fflags_q;
  assign bus.busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule
